// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - shared Morse code tables, A..Z dot/dash patterns and lengths
package morse_pkg;

    localparam int MORSE_DEPTH = 26;
    localparam int PAT_W_MAX   = 16;
    localparam int LEN_W       = 5;

    typedef logic [PAT_W_MAX-1:0] morse_pat_t;
    typedef logic [LEN_W-1:0]     morse_len_t;

    // Left-justified unit patterns: dot=1, dash=111, one low unit between symbols.
    localparam morse_pat_t MORSE_PAT [0:MORSE_DEPTH-1] = '{
        16'hB800, 16'hEA80, 16'hEBA0, 16'hEA00, 16'h8000, 16'hAE80, 16'hEE80, 16'hAA00,
        16'hA000, 16'hBBB8, 16'hEB80, 16'hBA80, 16'hEE00, 16'hE800, 16'hEEE0, 16'hBBA0,
        16'hEEB8, 16'hBA00, 16'hA800, 16'hE000, 16'hAE00, 16'hAB80, 16'hBB80, 16'hEAE0,
        16'hEBB8, 16'hEEA0
    };

    localparam morse_len_t MORSE_LEN [0:MORSE_DEPTH-1] = '{
        5'd5,  5'd9,  5'd11, 5'd7,  5'd1,  5'd9,  5'd9,  5'd7,
        5'd3,  5'd13, 5'd9,  5'd9,  5'd7,  5'd5,  5'd11, 5'd11,
        5'd13, 5'd7,  5'd5,  5'd3,  5'd7,  5'd9,  5'd9,  5'd11,
        5'd13, 5'd11
    };

endpackage

// File: rtl/morse_tick_gen.sv
// rtl/morse_tick_gen.sv - rate divider emitting a one-cycle tick every TICK_DIV clocks
module morse_tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/morse_tx.sv
// rtl/morse_tx.sv - Morse transmitter: variable-length patterns, busy/done, repeat with gap, abort
module morse_tx
    import morse_pkg::*;
#(
    parameter int  TICK_DIV  = 25000000,
    parameter int  PAT_W     = 16,
    parameter int  NUM_CHARS = 8,
    parameter int  GAP_UNITS = 7,
    localparam int SEL_W     = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [SEL_W-1:0] sel,
    input  logic             start,
    input  logic             repeat_en,
    input  logic             stop,
    output logic             led_out,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam int CNT_W = $clog2(PAT_W + 1);
    localparam int GAP_W = (GAP_UNITS > 1) ? $clog2(GAP_UNITS + 1) : 1;

    logic [1:0]       state_q, state_d;
    logic [PAT_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             led_q, led_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             tick;
    logic             tick_clr;
    logic             sel_ok;
    logic             char_end;
    logic [SEL_W-1:0] load_sel;
    logic [4:0]       pat_idx;
    logic [PAT_W-1:0] load_pat;
    logic [CNT_W-1:0] load_len;

    generate
        if (NUM_CHARS >= (1 << SEL_W)) begin : g_sel_full
            assign sel_ok = 1'b1;
        end else begin : g_sel_chk
            assign sel_ok = (sel < SEL_W'(NUM_CHARS));
        end
    endgenerate

    // Live sel only matters at acceptance; repeats reload from the latched copy.
    assign load_sel = (state_q == ST_IDLE) ? sel : sel_q;
    assign pat_idx  = 5'(load_sel);
    assign load_pat = PAT_W'(MORSE_PAT[pat_idx]) << (PAT_W - PAT_W_MAX);
    assign load_len = CNT_W'(MORSE_LEN[pat_idx]);

    assign tick_clr = (state_q == ST_IDLE) || stop;

    morse_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .clr_i   (tick_clr),
        .tick_o  (tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sel_d     = sel_q;
        done_d    = 1'b0;
        char_end  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop && sel_ok) begin
                    sel_d     = sel;
                    shreg_d   = load_pat;
                    bit_cnt_d = load_len;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (bit_cnt_q == '0) begin
                    char_end = 1'b1;
                end else if (tick) begin
                    shreg_d   = shreg_q << 1;
                    bit_cnt_d = bit_cnt_q - CNT_W'(1);
                    char_end  = (bit_cnt_q == CNT_W'(1));
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (gap_cnt_q <= GAP_W'(1)) begin
                        if (repeat_en) begin
                            shreg_d   = load_pat;
                            bit_cnt_d = load_len;
                            state_d   = ST_SHIFT;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (char_end) begin
            if (repeat_en) begin
                state_d   = ST_GAP;
                gap_cnt_d = GAP_W'(GAP_UNITS);
            end else begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    assign led_d  = (state_d == ST_SHIFT) && shreg_d[PAT_W-1];
    assign busy_d = (state_d != ST_IDLE);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            sel_q     <= '0;
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            sel_q     <= sel_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign led_out = led_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
